button_debouncer: RTL and testbench



---
 rtl/button_debouncer_pkg.sv | 15 +
 rtl/debounce_channel.sv | 92 +++++++++
 rtl/button_debouncer.sv | 38 +++
 tb/tb_button_debouncer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared constants and filter state encoding for the button debouncer.
package button_debouncer_pkg;

   localparam int CLK_FREQ_HZ           = 12_000_000;
   localparam int DEBOUNCE_MS_DEFAULT   = 20;
   localparam int STABLE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS_DEFAULT;

   typedef enum logic [1:0] {
      LOW          = 2'd0,
      LOW_PENDING  = 2'd1,
      HIGH         = 2'd2,
      HIGH_PENDING = 2'd3
   } filt_state_e;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: two-flop synchroniser, stability filter FSM and edge pulses.
//
// state        | meaning
// LOW          | accepted level 0, synchronised input agrees
// LOW_PENDING  | accepted level 0, input has been 1 for cnt_q+1 edges
// HIGH         | accepted level 1, synchronised input agrees
// HIGH_PENDING | accepted level 1, input has been 0 for cnt_q+1 edges
module debounce_channel
   import button_debouncer_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   filt_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= LOW;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Any cycle of agreement drops back to the stable state and clears the count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         LOW, LOW_PENDING: begin
            if (!sync2_q) begin
               state_d = LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HIGH;
               cnt_d   = '0;
               rise_d  = 1'b1;
            end else begin
               state_d = LOW_PENDING;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         HIGH, HIGH_PENDING: begin
            if (sync2_q) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = LOW;
               cnt_d   = '0;
               fall_d  = 1'b1;
            end else begin
               state_d = HIGH_PENDING;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
         end
      endcase
   end

   assign level_o = (state_q == HIGH) || (state_q == HIGH_PENDING);
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer feeding the gate exercises.
// Define BUTTON_DEBOUNCER_ACTIVE_LOW_EN for pull-up buttons (0 = pressed on btn_in).
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int WIDTH         = 2,
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] btn_in,
   output logic [WIDTH-1:0] btn_out,
   output logic [WIDTH-1:0] btn_rise,
   output logic [WIDTH-1:0] btn_fall
);

   logic [WIDTH-1:0] pressed;

`ifdef BUTTON_DEBOUNCER_ACTIVE_LOW_EN
   assign pressed = ~btn_in;
`else
   assign pressed = btn_in;
`endif

   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES)
      ) u_ch (
         .clk_i   (clk),
         .rst_i   (rst),
         .btn_i   (pressed[g]),
         .level_o (btn_out[g]),
         .rise_o  (btn_rise[g]),
         .fall_o  (btn_fall[g])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random traffic against a sliding-window model.
module tb_button_debouncer;

   localparam int S = 4;
   localparam int W = 2;

`ifdef BUTTON_DEBOUNCER_ACTIVE_LOW_EN
   localparam logic [W-1:0] INV = 2'b11;
`else
   localparam logic [W-1:0] INV = 2'b00;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] btn_in = '0;
   logic [W-1:0] btn_out, btn_rise, btn_fall;

   int vectors = 0;
   int miscompares = 0;

   // Model: level flips once the S filter-visible samples (btn samples from
   // edges k-S-1..k-2) all differ from it, counting only edges after reset.
   logic [W-1:0] hist[$];
   logic [W-1:0] m_out = '0;
   logic [W-1:0] m_rise = '0;
   logic [W-1:0] m_fall = '0;
   int           since = 0;

   button_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in),
      .btn_out  (btn_out),
      .btn_rise (btn_rise),
      .btn_fall (btn_fall)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] enc(input logic [W-1:0] p);
      return p ^ INV;
   endfunction

   task automatic step(input string tag, input logic r, input logic [W-1:0] b);
      logic [W-1:0] s;
      logic         all_diff;
      rst    = r;
      btn_in = b;
      @(posedge clk);
      s = b ^ INV;
      hist.push_back(s);
      m_rise = '0;
      m_fall = '0;
      if (r) begin
         m_out = '0;
         since = 0;
      end else begin
         since++;
         for (int ch = 0; ch < W; ch++) begin
            if (since >= S + 2) begin
               all_diff = 1'b1;
               for (int j = 2; j <= S + 1; j++)
                  if (hist[hist.size() - 1 - j][ch] == m_out[ch]) all_diff = 1'b0;
               if (all_diff) begin
                  m_out[ch] = ~m_out[ch];
                  if (m_out[ch]) m_rise[ch] = 1'b1;
                  else           m_fall[ch] = 1'b1;
               end
            end
         end
      end
      vectors++;
      #1;
      assert ({btn_out, btn_rise, btn_fall} === {m_out, m_rise, m_fall})
      else begin
         miscompares++;
         $error("FAIL %s out/rise/fall observed=%b expected=%b", tag,
                {btn_out, btn_rise, btn_fall}, {m_out, m_rise, m_fall});
      end
   endtask

   task automatic hold(input string tag, input logic [W-1:0] p, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, enc(p));
   endtask

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset held with both buttons pressed, then released: rise on the 6th edge.
      for (int i = 0; i < 3; i++) step("reset", 1'b1, enc(2'b11));
      chk("reset_outs", {btn_out, btn_rise, btn_fall}, 6'b000000);
      hold("rel_wait", 2'b11, 5);
      chk("rel_edge5", {btn_out, btn_rise, btn_fall}, 6'b000000);
      hold("rel_rise", 2'b11, 1);
      chk("rel_edge6", {btn_out, btn_rise, btn_fall}, 6'b111100);
      hold("rel_after", 2'b11, 1);
      chk("rel_edge7", {btn_out, btn_rise, btn_fall}, 6'b110000);

      // Release both, then a single-channel press.
      hold("both_release", 2'b00, 10);
      hold("ch0_press", 2'b01, 5);
      chk("ch0_edge5", {btn_out, btn_rise, btn_fall}, 6'b000000);
      hold("ch0_press6", 2'b01, 1);
      chk("ch0_edge6", {btn_out, btn_rise, btn_fall}, 6'b010100);
      hold("ch0_hold", 2'b01, 4);

      // Glitches: 3-cycle high pulse rejected, 4-cycle pulse accepted.
      hold("settle_low", 2'b00, 10);
      hold("glitch3", 2'b01, 3);
      hold("glitch3_after", 2'b00, 10);
      chk("glitch3_out", {btn_out, btn_rise, btn_fall}, 6'b000000);
      hold("pulse4", 2'b01, 4);
      hold("pulse4_after", 2'b00, 12);

      // Bouncing release on channel 1.
      hold("ch1_press", 2'b10, 10);
      hold("bounce_a", 2'b00, 1);
      hold("bounce_b", 2'b10, 1);
      hold("bounce_c", 2'b00, 1);
      hold("bounce_d", 2'b10, 1);
      hold("bounce_settle", 2'b00, 5);
      chk("bounce_edge5", {btn_out, btn_rise, btn_fall}, 6'b100000);
      hold("bounce_fall", 2'b00, 1);
      chk("bounce_edge6", {btn_out, btn_rise, btn_fall}, 6'b000010);
      hold("bounce_quiet", 2'b00, 6);

      // Reset while channel 0 is mid-count, then full latency again.
      hold("pend", 2'b01, 4);
      step("mid_reset", 1'b1, enc(2'b01));
      chk("mid_reset_outs", {btn_out, btn_rise, btn_fall}, 6'b000000);
      hold("post_reset", 2'b01, 5);
      chk("post_reset_edge5", {btn_out, btn_rise, btn_fall}, 6'b000000);
      hold("post_reset_rise", 2'b01, 1);
      chk("post_reset_edge6", {btn_out, btn_rise, btn_fall}, 6'b010100);
      hold("post_reset_hold", 2'b01, 4);

      // Random traffic with occasional resets.
      begin
         logic [W-1:0] b;
         b = enc(2'b01);
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
               step("rand_reset", 1'b1, b);
            end else begin
               if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 3));
               step("rand", 1'b0, b);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
